uart_receiver: RTL and testbench

//  Serial-to-parallel half of the UART IP: samples uart_rxd with the bclk oversampling tick,

---
 rtl/uart_receiver.sv | 194 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : uart_receiver
//  Purpose  : Oversampled UART receive path. Rebuilds 5..8-bit frames and
//             pushes them into the RX FIFO with parity/framing/break status.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       bclk,
    input  logic       osm_sel,
    input  logic       eps,
    input  logic       pen,
    input  logic       stb,
    input  logic [1:0] wls,
    input  logic       uart_rxd,
    input  logic       rx_full_status,
    output logic       rx_wr,
    output logic [7:0] rx_data,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_break,
    output logic       overrun_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [3:0]             cnt_q;
    logic [3:0]             cnt_d;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             shift_q;
    logic [1:0]             wls_q;
    logic                   pen_q;
    logic                   eps_q;
    logic                   par_q;
    logic                   brk_wait_q;

    logic                   rx_wr_q;
    logic [7:0]             rx_data_q;
    logic                   rx_perr_q;
    logic                   rx_ferr_q;
    logic                   rx_brk_q;
    logic                   ovr_q;

    logic                   w_rxs;
    logic [3:0]             w_osm_max;
    logic [3:0]             w_mid;
    logic                   w_last_bit;
    logic                   w_exp_par;
    logic                   w_perr;
    logic                   w_brk;
    logic                   w_unused_stb;

    // Only the first stop bit is examined, so the stop-bit count has no effect here.
    assign w_unused_stb = stb;

    assign w_rxs      = sync_q[SYNC_STAGES-1];
    assign w_osm_max  = osm_sel ? 4'd12 : 4'd15;
    assign w_mid      = osm_sel ? 4'd6  : 4'd7;
    assign w_last_bit = (bit_cnt_q == ({1'b0, wls_q} + 3'd4));
    assign w_exp_par  = eps_q ? (^shift_q) : (~^shift_q);
    assign w_perr     = pen_q && (par_q != w_exp_par);
    assign w_brk      = (shift_q == 8'h00) && !(pen_q && par_q) && !w_rxs;

    always_comb begin
        cnt_d = (cnt_q == w_osm_max) ? 4'd0 : cnt_q + 4'd1;
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q    <= S_IDLE;
            sync_q     <= '1;
            cnt_q      <= 4'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            wls_q      <= 2'b00;
            pen_q      <= 1'b0;
            eps_q      <= 1'b0;
            par_q      <= 1'b0;
            brk_wait_q <= 1'b0;
            rx_wr_q    <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_brk_q   <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1) begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
            end else begin
                sync_q <= uart_rxd;
            end
            rx_wr_q <= 1'b0;
            ovr_q   <= 1'b0;

            if (bclk) begin
                case (state_q)
                    S_IDLE: begin
                        cnt_q <= 4'd0;
                        // After a break the line must return high before a new start is armed.
                        if (brk_wait_q) begin
                            if (w_rxs) begin
                                brk_wait_q <= 1'b0;
                            end
                        end else if (!w_rxs) begin
                            state_q <= S_START;
                            cnt_q   <= 4'd1;
                            wls_q   <= wls;
                            pen_q   <= pen;
                            eps_q   <= eps;
                            shift_q <= 8'h00;
                        end
                    end
                    S_START: begin
                        cnt_q <= cnt_d;
                        if ((cnt_q == w_mid) && w_rxs) begin
                            state_q <= S_IDLE;
                            cnt_q   <= 4'd0;
                        end else if (cnt_q == w_osm_max) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        cnt_q <= cnt_d;
                        if (cnt_q == w_mid) begin
                            shift_q[bit_cnt_q] <= w_rxs;
                        end
                        if (cnt_q == w_osm_max) begin
                            if (w_last_bit) begin
                                state_q <= pen_q ? S_PARITY : S_STOP;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        cnt_q <= cnt_d;
                        if (cnt_q == w_mid) begin
                            par_q <= w_rxs;
                        end
                        if (cnt_q == w_osm_max) begin
                            state_q <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        cnt_q <= cnt_d;
                        if (cnt_q == w_mid) begin
                            // A full FIFO keeps the previously delivered word and its status.
                            if (rx_full_status) begin
                                ovr_q <= 1'b1;
                            end else begin
                                rx_wr_q   <= 1'b1;
                                rx_data_q <= shift_q;
                                rx_perr_q <= w_perr;
                                rx_ferr_q <= !w_rxs;
                                rx_brk_q  <= w_brk;
                            end
                            if (w_brk) begin
                                brk_wait_q <= 1'b1;
                            end
                            state_q <= S_IDLE;
                            cnt_q   <= 4'd0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign rx_wr         = rx_wr_q;
    assign rx_data       = rx_data_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_break      = rx_brk_q;
    assign overrun_err   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_receiver
//  Purpose  : Directed and randomized frames against a frame-level model of
//             the UART receiver.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int PCLK_PER_TICK = 4;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       bclk;
    logic       osm_sel = 1'b0;
    logic       eps = 1'b0;
    logic       pen = 1'b0;
    logic       stb = 1'b0;
    logic [1:0] wls = 2'b11;
    logic       uart_rxd = 1'b1;
    logic       rx_full_status = 1'b0;
    logic       rx_wr;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_break;
    logic       overrun_err;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int ovr_cnt = 0;
    int wide_cnt = 0;
    logic wr_prev = 1'b0;
    logic ovr_prev = 1'b0;
    int tick_div = 0;

    logic [7:0] m_data = 8'h00;
    logic       m_perr = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_brk  = 1'b0;

    uart_receiver #(.SYNC_STAGES(2)) dut (
        .pclk           (pclk),
        .presetn        (presetn),
        .bclk           (bclk),
        .osm_sel        (osm_sel),
        .eps            (eps),
        .pen            (pen),
        .stb            (stb),
        .wls            (wls),
        .uart_rxd       (uart_rxd),
        .rx_full_status (rx_full_status),
        .rx_wr          (rx_wr),
        .rx_data        (rx_data),
        .rx_parity_err  (rx_parity_err),
        .rx_frame_err   (rx_frame_err),
        .rx_break       (rx_break),
        .overrun_err    (overrun_err)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        tick_div <= (tick_div == PCLK_PER_TICK - 1) ? 0 : tick_div + 1;
    end
    assign bclk = (tick_div == PCLK_PER_TICK - 1);

    always @(negedge pclk) begin
        if (rx_wr) wr_cnt++;
        if (rx_wr && wr_prev) wide_cnt++;
        if (overrun_err) ovr_cnt++;
        if (overrun_err && ovr_prev) wide_cnt++;
        wr_prev  = rx_wr;
        ovr_prev = overrun_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_level(input logic b, input int ticks);
        uart_rxd = b;
        repeat (ticks * PCLK_PER_TICK) @(negedge pclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] w, input logic p,
                              input logic e, input logic pb, input logic st,
                              input logic sb, input logic osm);
        int ospt;
        int midt;
        ospt = osm ? 13 : 16;
        midt = osm ? 6 : 7;
        osm_sel = osm;
        wls = w;
        pen = p;
        eps = e;
        stb = sb;
        drive_level(1'b0, ospt);
        for (int i = 0; i < int'(w) + 5; i++) drive_level(d[i], ospt);
        if (p) drive_level(pb, ospt);
        if (st) begin
            drive_level(1'b1, ospt);
        end else begin
            drive_level(1'b0, midt + 4);
            drive_level(1'b1, ospt - midt - 4);
        end
        if (sb) drive_level(1'b1, ospt);
        drive_level(1'b1, 2 * ospt);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data"}, rx_data, m_data);
        check({tag, ".perr"}, rx_parity_err, m_perr);
        check({tag, ".ferr"}, rx_frame_err, m_ferr);
        check({tag, ".brk"}, rx_break, m_brk);
    endtask

    task automatic rx_frame(input string tag, input logic [7:0] d, input logic [1:0] w,
                            input logic p, input logic e, input logic pb, input logic st,
                            input logic sb, input logic osm, input logic full);
        int wr0;
        int ovr0;
        logic [7:0] mask;
        logic [7:0] dm;
        logic exp_par;
        wr0  = wr_cnt;
        ovr0 = ovr_cnt;
        rx_full_status = full;
        send_frame(d, w, p, e, pb, st, sb, osm);
        rx_full_status = 1'b0;
        mask = 8'hFF >> (3 - int'(w));
        dm = d & mask;
        exp_par = e ? (^dm) : ~(^dm);
        if (!full) begin
            m_data = dm;
            m_perr = p && (pb != exp_par);
            m_ferr = !st;
            m_brk  = (dm == 8'h00) && !(p && pb) && !st;
        end
        check({tag, ".wr"}, wr_cnt - wr0, full ? 0 : 1);
        check({tag, ".ovr"}, ovr_cnt - ovr0, full ? 1 : 0);
        check_outputs(tag);
    endtask

    initial begin
        int wr0;
        presetn = 1'b0;
        repeat (3) @(negedge pclk);
        check("reset.wr", rx_wr, 0);
        check("reset.ovr", overrun_err, 0);
        check_outputs("reset");
        presetn = 1'b1;
        drive_level(1'b1, 4);

        rx_frame("t1", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t1.width", wide_cnt, 0);

        rx_frame("t2a", 8'h1F, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        rx_frame("t2b", 8'h1F, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        osm_sel = 1'b0;
        wls = 2'b11;
        pen = 1'b0;
        wr0 = wr_cnt;
        drive_level(1'b0, 3);
        drive_level(1'b1, 40);
        check("t3.glitch_wr", wr_cnt - wr0, 0);
        rx_frame("t3", 8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        rx_frame("t4a", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Break: line low well past the frame, then released.
        wr0 = wr_cnt;
        osm_sel = 1'b0;
        wls = 2'b11;
        pen = 1'b0;
        drive_level(1'b0, 10 * 16 + 24);
        drive_level(1'b1, 32);
        m_data = 8'h00;
        m_perr = 1'b0;
        m_ferr = 1'b1;
        m_brk  = 1'b1;
        check("t4b.wr", wr_cnt - wr0, 1);
        check_outputs("t4b");

        for (int k = 0; k < 12; k++) begin
            logic [7:0] rd;
            logic [1:0] rw;
            rd = 8'($urandom);
            rw = 2'($urandom_range(0, 3));
            rx_frame($sformatf("rnd%0d", k), rd, rw, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
        end

        rx_frame("t5pre", 8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rx_frame("t5", 8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t5.width", wide_cnt, 0);

        // Reset pulse late in data bit 3 of 0xF0.
        osm_sel = 1'b0;
        wls = 2'b11;
        pen = 1'b0;
        wr0 = wr_cnt;
        drive_level(1'b0, 16);
        drive_level(1'b0, 48);
        drive_level(1'b0, 14);
        presetn = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        m_data = 8'h00;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_brk  = 1'b0;
        check("t6.rst_wr", rx_wr, 0);
        check("t6.rst_ovr", overrun_err, 0);
        check_outputs("t6.rst");
        drive_level(1'b0, 2);
        drive_level(1'b1, 64 + 16 + 32);
        check("t6.no_wr", wr_cnt - wr0, 0);
        rx_frame("t6", 8'h0F, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        check("pulse_width", wide_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
